// File: rtl/csa_pipe_adder_if.sv
// Operand/result handshake bundle for csa_pipe_adder.
// The master drives operands and out_ready; the slave is the adder.
interface csa_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder: P0 precomputes per-group sums and BEC (+1) candidates,
// stages S1..SK resolve SEL_PER_STAGE groups each. CSA_PIPE_OVF_EN builds the signed overflow output.
module csa_pipe_adder #(
  parameter int WIDTH         = 32,
  parameter int GROUP         = 8,
  parameter int SEL_PER_STAGE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  localparam int K  = NG / SEL_PER_STAGE;

  typedef logic [NG-1:0][GROUP:0] cand_t;

  // Binary-to-excess-1: flip each bit whose lower bits are all ones.
  function automatic logic [GROUP:0] bec(input logic [GROUP:0] t);
    logic [GROUP:0] r;
    logic           c;
    r = '0;
    c = 1'b1;
    for (int i = 0; i <= GROUP; i++) begin
      r[i] = t[i] ^ c;
      c    = c & t[i];
    end
    return r;
  endfunction

  logic             adv_s;
  cand_t            t0_s;
  cand_t            t1_s;
  logic [WIDTH-1:0] sum_s   [1:K];
  logic             carry_s [1:K];

  logic             valid_r [0:K];
  cand_t            t0_r    [0:K-1];
  cand_t            t1_r    [0:K-1];
  logic [WIDTH-1:0] sum_r   [0:K];
  logic             carry_r [0:K];

  assign adv_s = !(valid_r[K] && !bus.out_ready);

  // P0 candidates; group 0 already includes cin, so both of its slots hold the final value.
  always_comb begin
    t0_s = '0;
    t1_s = '0;
    for (int g = 0; g < NG; g++) begin
      if (g == 0) begin
        t0_s[g] = {1'b0, bus.x[GROUP-1:0]} + {1'b0, bus.y[GROUP-1:0]}
                + {{GROUP{1'b0}}, bus.cin};
        t1_s[g] = t0_s[g];
      end else begin
        t0_s[g] = {1'b0, bus.x[g*GROUP +: GROUP]} + {1'b0, bus.y[g*GROUP +: GROUP]};
        t1_s[g] = bec(t0_s[g]);
      end
    end
  end

  // Carry-select resolution of each stage's groups from the previous stage registers.
  always_comb begin
    logic [GROUP:0] sel;
    int             g;
    sel = '0;
    g   = 0;
    for (int k = 1; k <= K; k++) begin
      sum_s[k]   = sum_r[k-1];
      carry_s[k] = carry_r[k-1];
      for (int j = 0; j < SEL_PER_STAGE; j++) begin
        g   = (k - 1) * SEL_PER_STAGE + j;
        sel = carry_s[k] ? t1_r[k-1][g] : t0_r[k-1][g];
        sum_s[k][g*GROUP +: GROUP] = sel[GROUP-1:0];
        carry_s[k] = sel[GROUP];
      end
    end
  end

`ifdef CSA_PIPE_OVF_EN
  logic xm_r [0:K];
  logic ym_r [0:K];

  // Operand sign bits travel alongside their beat for the overflow test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= K; k++) begin
        xm_r[k] <= 1'b0;
        ym_r[k] <= 1'b0;
      end
    end else if (adv_s) begin
      xm_r[0] <= bus.x[WIDTH-1];
      ym_r[0] <= bus.y[WIDTH-1];
      for (int k = 1; k <= K; k++) begin
        xm_r[k] <= xm_r[k-1];
        ym_r[k] <= ym_r[k-1];
      end
    end
  end

  assign bus.ovf = (xm_r[K] == ym_r[K]) && (sum_r[K][WIDTH-1] != xm_r[K]);
`else
  assign bus.ovf = 1'b0;
`endif

  // Whole pipeline advances together; a stall freezes every stage including bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= K; k++) begin
        valid_r[k] <= 1'b0;
        sum_r[k]   <= '0;
        carry_r[k] <= 1'b0;
      end
      for (int k = 0; k < K; k++) begin
        t0_r[k] <= '0;
        t1_r[k] <= '0;
      end
    end else if (adv_s) begin
      valid_r[0] <= bus.in_valid;
      t0_r[0]    <= t0_s;
      t1_r[0]    <= t1_s;
      sum_r[0]   <= '0;
      carry_r[0] <= 1'b0;
      for (int k = 1; k <= K; k++) begin
        valid_r[k] <= valid_r[k-1];
        sum_r[k]   <= sum_s[k];
        carry_r[k] <= carry_s[k];
      end
      for (int k = 1; k < K; k++) begin
        t0_r[k] <= t0_r[k-1];
        t1_r[k] <= t1_r[k-1];
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = valid_r[K];
  assign bus.s         = sum_r[K];
  assign bus.cout      = carry_r[K];
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed/self-checking bench for csa_pipe_adder at default parameters (latency 3).
module tb_csa_pipe_adder;
`ifdef CSA_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [32:0] exp_q [$];

  csa_pipe_adder_if #(.WIDTH(32)) bus ();

  csa_pipe_adder #(.WIDTH(32), .GROUP(8), .SEL_PER_STAGE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] rs, output logic rc, output logic ro,
                          output int lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.x = a; bus.y = b; bus.cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = -1; rs = 32'h0; rc = 1'b0; ro = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.out_valid) begin
        lat = i; rs = bus.s; rc = bus.cout; ro = bus.ovf;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = 32'h0; bus.y = 32'h0; bus.cin = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.s !== 32'h0) begin errors++; $display("FAIL reset_s got=%h exp=0", bus.s); end
    checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_cout_ovf got=%b%b exp=00", bus.cout, bus.ovf); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got=%b exp=1 (out_ready=0, empty)", bus.in_ready); end
  endtask

  task automatic test_carry_chain();
    logic [31:0] rs; logic rc; logic ro; int lat;
    send_one(32'hFFFFFFFF, 32'h0, 1'b1, rs, rc, ro, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL chain_latency got=%0d exp=3", lat); end
    checks++; if (rs !== 32'h0 || rc !== 1'b1) begin errors++; $display("FAIL chain_sum got=%b_%h exp=1_00000000", rc, rs); end
  endtask

  task automatic test_group_boundaries();
    logic [31:0] rs; logic rc; logic ro; int lat;
    send_one(32'h00FF00FF, 32'h00010001, 1'b0, rs, rc, ro, lat);
    checks++; if (lat != 3 || rs !== 32'h01000100 || rc !== 1'b0) begin errors++; $display("FAIL group_a got=%b_%h lat=%0d exp=0_01000100 lat=3", rc, rs, lat); end
    send_one(32'h80808080, 32'h80808080, 1'b1, rs, rc, ro, lat);
    checks++; if (lat != 3 || rs !== 32'h01010101 || rc !== 1'b1) begin errors++; $display("FAIL group_b got=%b_%h lat=%0d exp=1_01010101 lat=3", rc, rs, lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] rs; logic rc; logic ro; int lat;
    send_one(32'h7FFFFFFF, 32'h00000001, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'h80000000 || rc !== 1'b0 || ro !== OVF_ON) begin errors++; $display("FAIL ovf_pos got=%b_%h ovf=%b exp=0_80000000 ovf=%b", rc, rs, ro, OVF_ON); end
    send_one(32'h80000000, 32'h80000000, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'h0 || rc !== 1'b1 || ro !== OVF_ON) begin errors++; $display("FAIL ovf_neg got=%b_%h ovf=%b exp=1_00000000 ovf=%b", rc, rs, ro, OVF_ON); end
    send_one(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 32'h7FFFFFFE || rc !== 1'b1 || ro !== 1'b0) begin errors++; $display("FAIL ovf_none got=%b_%h ovf=%b exp=1_7ffffffe ovf=0", rc, rs, ro); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a; logic [31:0] b; logic c; logic [32:0] e;
    int sent; int got; int gaps; bit started;
    exp_q.delete();
    sent = 0; got = 0; gaps = 0; started = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 140 && got < 100; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        started = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL stream_extra got=%b_%h exp=no result", bus.cout, bus.s);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({bus.cout, bus.s} !== e) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", got, {bus.cout, bus.s}, e); end
        end
        got++;
      end else if (started) begin
        gaps++;
      end
      if (sent < 100) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(1, 0));
        bus.x = a; bus.y = b; bus.cin = c; bus.in_valid = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {32'h0, c});
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 100 || gaps != 0) begin errors++; $display("FAIL stream_count got=%0d gaps=%0d exp=100 gaps=0", got, gaps); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a; logic [31:0] b; logic [32:0] e; logic [32:0] head; int got;
    exp_q.delete();
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      a = 32'h11111111 * (i + 1) + 32'hF0F0F000; b = 32'h0F0F0FFF + i;
      bus.x = a; bus.y = b; bus.cin = i[0]; bus.in_valid = 1'b1;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {32'h0, i[0]});
    end
    head = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || {bus.cout, bus.s} !== head) begin
        errors++; $display("FAIL stall[%0d] got rdy=%b vld=%b res=%h exp rdy=0 vld=1 res=%h", i, bus.in_ready, bus.out_valid, {bus.cout, bus.s}, head);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_duplicate got=%h exp=no result", {bus.cout, bus.s});
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({bus.cout, bus.s} !== e) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, {bus.cout, bus.s}, e); end
        end
        got++;
      end
      if (c == 1) bus.in_valid = 1'b0;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
  endtask

  task automatic test_reset_midflight();
    int stale;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x = 32'hA5A5A5A5 + i; bus.y = 32'h5A5A5A5A; bus.cin = 1'b1; bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.s !== 32'h0) begin errors++; $display("FAIL midreset got vld=%b s=%h exp vld=0 s=0", bus.out_valid, bus.s); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midreset_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_carry_chain();
    test_group_boundaries();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder using Binary-to-Excess-1 converters (BEC). It generalises the fixed 32-bit combinational carry-select adder in four ways: configurable width, uniform group size, carry-in, and a registered carry-select chain with valid/ready flow control. It sits in the adders library as the throughput-oriented datapath adder. The same sum/BEC/mux structure is kept per group.

## Interface
Parameters:
- WIDTH, 32, operand width in bits.
- GROUP, 8, bits per carry-select group. WIDTH % GROUP == 0 is required.
- SEL_PER_STAGE, 2, carry-select groups resolved per pipeline stage. NG = WIDTH/GROUP, and NG % SEL_PER_STAGE == 0 is required.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum.
- cout  out  1  carry-out.
- ovf  out  1  signed two's-complement overflow (see Configuration).

## Operation
- Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
- Stage P0 (precompute):
  - Group 0 is added with the real cin.
  - Each group g ≥ 1 computes a GROUP-bit RCA sum with cin=0, plus a carry, forming the (GROUP+1)-bit value t_g.
  - A (GROUP+1)-bit BEC produces t_g+1 (modulo 2^(GROUP+1)).
  - The P0 register captures group 0's final sum/carry and, for every other group, both t_g and t_g+1.
- Stages S1..SK, with K = NG/SEL_PER_STAGE:
  - Stage k resolves groups (k-1)*SEL_PER_STAGE .. k*SEL_PER_STAGE-1 by muxing t_g vs t_g+1 using the incoming carry. Group 0 passes through.
  - The resolved carry and sum bits are registered. Unresolved groups carry their candidate pairs forward.
- Output register = SK. s = resolved sum, cout = final group carry.
- ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]). The operand MSBs needed for this travel with the pipeline.
- Each stage has a valid bit that shifts in lockstep with the data.
- Flow control is a global stall: in_ready = !(out_valid && !out_ready).
  - When stalled, every stage register and valid bit holds.
  - Otherwise all stages advance, including bubbles, which shift as valid=0.
- Arithmetic: {cout, s} == x + y + cin exactly, for all operands (modulo 2^(WIDTH+1)).

## Timing
- Latency is L = 1 + K cycles from the input transfer edge to out_valid, with no stall. Default L = 3.
- Throughput is one result per cycle while out_ready stays high.
- Reset (rst_n low, asynchronous): all valid bits 0, s=0, cout=0, ovf=0, out_valid=0. in_ready=1 during and after reset.
- Reset mid-operation discards every in-flight beat; no partial result is emitted.
- Stall while a stage holds valid data: s/cout/ovf are stable until the transfer out.
- Bubbles fill freely: if out_valid=0, in_ready=1 regardless of out_ready.
- A simultaneous output transfer and input transfer is legal; the pipeline advances by one.

## Configuration
- CSA_PIPE_OVF_EN:
  - Defined: the MSB-tracking registers and the overflow logic are built, and ovf follows the rule in Operation.
  - Undefined: none of that is built, and ovf is tied to 0. The port remains so the interface is unchanged.

## Test plan
All scenarios use the default parameters: WIDTH=32, GROUP=8, SEL_PER_STAGE=2, L=3.
- Carry chain: x=32'hFFFFFFFF, y=0, cin=1 → s=0, cout=1, out_valid rises exactly 3 cycles after acceptance.
- Streaming: 100 back-to-back random beats with out_ready=1 → 100 results in order, each matching x+y+cin, with no gaps.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full → in_ready=0, s/cout stable. Release → results resume in order with no loss or duplication.
- Overflow (macro on): x=32'h7FFFFFFF, y=1, cin=0 → s=32'h80000000, ovf=1. With x=32'h80000000, y=32'h80000000 → s=0, cout=1, ovf=1. With the macro off, ovf=0 in both cases.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight → out_valid=0 and s=0 immediately. After release, no stale result ever appears.
- Group boundaries: x=32'h00FF00FF, y=32'h00010001, cin=0 → s=32'h01000100, cout=0. With x=32'h80808080, y=32'h80808080, cin=1 → s=32'h01010101, cout=1.
